// File: rtl/eth_parser.sv
// Ethernet II / IPv4 / UDP receive filter: checks MAC, EtherType, IP checksum/address and UDP port,
// then streams the UDP payload. Define ETH_PARSER_BROADCAST_EN to also accept FF:FF:FF:FF:FF:FF.
module eth_parser #(
  parameter logic [47:0] FPGA_MAC  = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP   = 32'hC0_00_02_92,
  parameter logic [15:0] FPGA_PORT = 16'd5005
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       data_valid,
  input  logic [7:0] received_byte,
  input  logic       byte_valid,
  output logic [7:0] payload,
  output logic       payload_valid,
  output logic       payload_last
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StPayload, StDrop
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [7:0]  hi_q;
  logic [15:0] csum_q;
  logic [15:0] udp_len_q;
  logic [15:0] remain_q;

  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic        mac_hit;
  logic [15:0] word;
  logic [16:0] csum_sum;
  logic [15:0] csum_fold;

  always_comb begin
    mac_byte = 8'h00;
    case (cnt_q)
      5'd0:    mac_byte = FPGA_MAC[47:40];
      5'd1:    mac_byte = FPGA_MAC[39:32];
      5'd2:    mac_byte = FPGA_MAC[31:24];
      5'd3:    mac_byte = FPGA_MAC[23:16];
      5'd4:    mac_byte = FPGA_MAC[15:8];
      5'd5:    mac_byte = FPGA_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_comb begin
    ip_byte = 8'h00;
    case (cnt_q)
      5'd16:   ip_byte = FPGA_IP[31:24];
      5'd17:   ip_byte = FPGA_IP[23:16];
      5'd18:   ip_byte = FPGA_IP[15:8];
      5'd19:   ip_byte = FPGA_IP[7:0];
      default: ip_byte = 8'h00;
    endcase
  end

  // Ones'-complement add with a single end-around carry; one fold suffices for 16+16 bits.
  assign word      = {hi_q, received_byte};
  assign csum_sum  = {1'b0, csum_q} + {1'b0, word};
  assign csum_fold = csum_sum[15:0] + {15'd0, csum_sum[16]};

`ifdef ETH_PARSER_BROADCAST_EN
  logic uni_q, bc_q, uni_d, bc_d;

  // Track unicast and broadcast matches separately so a mixed address is rejected.
  always_comb begin
    uni_d   = ((cnt_q == 5'd0) | uni_q) & (received_byte == mac_byte);
    bc_d    = ((cnt_q == 5'd0) | bc_q) & (received_byte == 8'hFF);
    mac_hit = uni_d | bc_d;
  end
`else
  assign mac_hit = (received_byte == mac_byte);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= 5'd0;
      hi_q          <= 8'h00;
      csum_q        <= 16'h0000;
      udp_len_q     <= 16'h0000;
      remain_q      <= 16'h0000;
      payload       <= 8'h00;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
`ifdef ETH_PARSER_BROADCAST_EN
      uni_q         <= 1'b0;
      bc_q          <= 1'b0;
`endif
    end else begin
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      if (!data_valid) begin
        state_q <= StIdle;
        cnt_q   <= 5'd0;
        csum_q  <= 16'h0000;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StPreamble;
            cnt_q   <= 5'd0;
            csum_q  <= 16'h0000;
          end
          StPreamble: begin
            if (byte_valid) begin
              if (received_byte == 8'hD5) begin
                state_q <= StEthHdr;
                cnt_q   <= 5'd0;
              end else if (received_byte != 8'h55) begin
                state_q <= StDrop;
              end
            end
          end
          StEthHdr: begin
            if (byte_valid) begin
              hi_q  <= received_byte;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q <= 5'd5) begin
`ifdef ETH_PARSER_BROADCAST_EN
                uni_q <= uni_d;
                bc_q  <= bc_d;
`endif
                if (!mac_hit) state_q <= StDrop;
              end else if (cnt_q == 5'd13) begin
                cnt_q  <= 5'd0;
                csum_q <= 16'h0000;
                state_q <= (word == 16'h0800) ? StIpHdr : StDrop;
              end
            end
          end
          StIpHdr: begin
            if (byte_valid) begin
              hi_q  <= received_byte;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q[0]) csum_q <= csum_fold;
              if (cnt_q >= 5'd16 && received_byte != ip_byte) begin
                state_q <= StDrop;
              end else if (cnt_q == 5'd19) begin
                cnt_q   <= 5'd0;
                state_q <= (csum_fold == 16'hFFFF) ? StUdpHdr : StDrop;
              end
            end
          end
          StUdpHdr: begin
            if (byte_valid) begin
              hi_q  <= received_byte;
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd3 && word != FPGA_PORT) state_q <= StDrop;
              if (cnt_q == 5'd5) udp_len_q <= word;
              if (cnt_q == 5'd7) begin
                cnt_q <= 5'd0;
                if (udp_len_q <= 16'd8) begin
                  state_q <= StDrop;
                end else begin
                  remain_q <= udp_len_q - 16'd8;
                  state_q  <= StPayload;
                end
              end
            end
          end
          StPayload: begin
            if (byte_valid) begin
              payload       <= received_byte;
              payload_valid <= 1'b1;
              remain_q      <= remain_q - 16'd1;
              if (remain_q == 16'd1) begin
                payload_last <= 1'b1;
                state_q      <= StDrop;
              end
            end
          end
          StDrop:  state_q <= StDrop;
          default: state_q <= StDrop;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_parser.sv
// Directed bench for eth_parser: builds frames byte by byte and compares the payload strobes.
module tb_eth_parser;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] received_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic [7:0] payload;
  logic       payload_valid;
  logic       payload_last;

  int checks = 0;
  int failures = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] fb[$];

  localparam logic [47:0] GoodMac = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [31:0] GoodIp  = 32'hC0_00_02_92;

  eth_parser dut (
    .clk           (clk),
    .resetn        (resetn),
    .data_valid    (data_valid),
    .received_byte (received_byte),
    .byte_valid    (byte_valid),
    .payload       (payload),
    .payload_valid (payload_valid),
    .payload_last  (payload_last)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (payload_valid) got_q.push_back({payload_last, payload});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [47:0] mac, input logic [15:0] et, input logic [15:0] cs,
                             input logic [31:0] ip, input logic [15:0] port,
                             input logic [15:0] len);
    fb.delete();
    repeat (7) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fb.push_back(mac[8*i +: 8]);
    repeat (6) fb.push_back(8'h8E);
    fb.push_back(et[15:8]); fb.push_back(et[7:0]);
    fb.push_back(8'h8E); fb.push_back(8'h8E); fb.push_back(8'h00); fb.push_back(8'h20);
    repeat (6) fb.push_back(8'h8E);
    fb.push_back(cs[15:8]); fb.push_back(cs[7:0]);
    repeat (4) fb.push_back(8'h8E);
    for (int i = 3; i >= 0; i--) fb.push_back(ip[8*i +: 8]);
    fb.push_back(8'h8E); fb.push_back(8'h8E);
    fb.push_back(port[15:8]); fb.push_back(port[7:0]);
    fb.push_back(len[15:8]); fb.push_back(len[7:0]);
    fb.push_back(8'h8E); fb.push_back(8'h8E);
    fb.push_back(8'hDE); fb.push_back(8'hAD); fb.push_back(8'hBE); fb.push_back(8'hEF);
    repeat (4) fb.push_back(8'h8E);
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      received_byte = fb[i];
      byte_valid    = 1'b1;
      @(negedge clk);
      byte_valid    = 1'b0;
    end
  endtask

  task automatic open_frame();
    @(negedge clk);
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic close_frame();
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame();
    got_q.delete();
    open_frame();
    send_bytes(fb.size());
    close_frame();
  endtask

  // Expected DEADBEEF sequence, truncated to n bytes with last on the final one.
  task automatic push_expected(input int n);
    logic [7:0] pl[4];
    pl[0] = 8'hDE; pl[1] = 8'hAD; pl[2] = 8'hBE; pl[3] = 8'hEF;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), pl[i]});
  endtask

  task automatic compare(input string tag);
    logic [8:0] obs;
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? got_q[i] : 9'h1FF;
      check_eq($sformatf("%s_byte%0d", tag, i), {23'd0, obs}, {23'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_payload", {24'd0, payload}, 32'd0);
    check_eq("reset_valid", {31'd0, payload_valid}, 32'd0);
    check_eq("reset_last", {31'd0, payload_last}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    run_frame();
    push_expected(4);
    compare("valid");
    check_eq("hold_payload", {24'd0, payload}, 32'h0000_00EF);

    build_frame(48'h10_1A_2B_3C_4D_5E, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    run_frame();
    compare("bad_mac");

    build_frame(GoodMac, 16'h86DD, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    run_frame();
    compare("bad_ethertype");

    build_frame(GoodMac, 16'h0800, 16'hE5F6, GoodIp, 16'd5005, 16'h000C);
    run_frame();
    compare("bad_checksum");

    build_frame(GoodMac, 16'h0800, 16'hE5F5, 32'hC0AA0292, 16'd5005, 16'h000C);
    run_frame();
    compare("bad_ip");

    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd8001, 16'h000C);
    run_frame();
    compare("bad_port");

    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h0008);
    run_frame();
    compare("len_8");

    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000A);
    run_frame();
    push_expected(2);
    compare("len_10");

    // Back-to-back frames separated by a single low clock.
    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    got_q.delete();
    open_frame();
    send_bytes(fb.size());
    @(negedge clk);
    data_valid = 1'b0;
    @(negedge clk);
    data_valid = 1'b1;
    repeat (2) @(negedge clk);
    send_bytes(fb.size());
    close_frame();
    push_expected(4);
    push_expected(4);
    compare("back_to_back");

    // Reset while the first payload byte is on the outputs.
    got_q.delete();
    open_frame();
    send_bytes(51);
    check_eq("pre_reset_valid", {31'd0, payload_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("async_reset_payload", {24'd0, payload}, 32'd0);
    check_eq("async_reset_valid", {31'd0, payload_valid}, 32'd0);
    check_eq("async_reset_last", {31'd0, payload_last}, 32'd0);
    data_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    build_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    run_frame();
`ifdef ETH_PARSER_BROADCAST_EN
    push_expected(4);
`endif
    compare("broadcast");

    build_frame(GoodMac, 16'h0800, 16'hE5F5, GoodIp, 16'd5005, 16'h000C);
    run_frame();
    push_expected(4);
    compare("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_parser.md
Name: eth_parser

Overview:
- Receive-side Ethernet II / IPv4 / UDP frame filter.
- Sits after the RMII byte assembler (LAN8720 PHY) and consumes one byte per `byte_valid` strobe.
- Checks destination MAC, EtherType, IPv4 header checksum, destination IP and destination UDP port, then streams the UDP payload bytes out.
- Frames that fail any check produce no output.

Parameters:
- FPGA_MAC, 48'h00_1A_2B_3C_4D_5E, station MAC address that frames must be addressed to.
- FPGA_IP, 32'hC0_00_02_92, station IPv4 address (192.0.2.146).
- FPGA_PORT, 16'd5005, accepted UDP destination port.

Ports:
- clk  in  1  50 MHz RMII reference clock; sole clock.
- resetn  in  1  reset, asynchronous, active-low.
- data_valid  in  1  frame envelope; high for the whole frame including preamble.
- received_byte  in  8  received byte, qualified by byte_valid.
- byte_valid  in  1  one-cycle strobe per received byte.
- payload  out  8  UDP payload byte.
- payload_valid  out  1  one-cycle strobe per payload byte.
- payload_last  out  1  high together with payload_valid on the final payload byte.

Behaviour:
- Reset values: payload=0, payload_valid=0, payload_last=0, state=IDLE, all counters and accumulators cleared.
- A byte is consumed only on a clock where byte_valid=1 and data_valid=1. If byte_valid=1 while data_valid=0, the byte is ignored.
- Abort: if data_valid=0 on any clock edge, the next state is IDLE from every state, and any unfinished payload is truncated without payload_last. A one-cycle low gap between back-to-back frames must therefore be honoured.
- IDLE: data_valid=1 → PREAMBLE.
- PREAMBLE:
  - byte 0x55 → stay.
  - byte 0xD5 → ETH_HDR.
  - any other byte → DROP.
- ETH_HDR, 14 bytes, MSB first:
  - bytes 0-5 compared to FPGA_MAC; a mismatch on any byte → DROP.
  - bytes 6-11 (source MAC) ignored.
  - bytes 12-13 must equal 0x0800, otherwise DROP.
- IP_HDR: exactly 20 bytes. The IHL field is not used.
  - Accumulate a 16-bit ones'-complement sum of all ten big-endian words, including the checksum field, using an end-around carry fold.
  - Bytes 16-19 compared to FPGA_IP; a mismatch → DROP.
  - After byte 19, the folded sum must equal 0xFFFF, otherwise DROP.
  - Version, total length, TTL, protocol and source IP are not checked.
- UDP_HDR, 8 bytes:
  - bytes 2-3 must equal FPGA_PORT, otherwise DROP.
  - bytes 4-5 latched as the 16-bit UDP length. Payload count = length−8.
  - If length ≤ 8, the frame has no payload → DROP after byte 7.
  - bytes 6-7 (UDP checksum) ignored.
- PAYLOAD:
  - On each consumed byte: payload<=received_byte and payload_valid<=1 for one cycle. The output is registered, appearing the clock after the strobe.
  - payload_last=1 on byte number count−1; then → DROP.
  - Trailing bytes (padding, FCS) are ignored. FCS is not checked.
- DROP: ignore all bytes until data_valid=0, then IDLE.
- payload_valid and payload_last are 0 on every cycle without a new payload byte. The payload register holds its value between strobes.

Optional Feature:
- Macro ETH_PARSER_BROADCAST_EN.
- Defined: a destination MAC of FF:FF:FF:FF:FF:FF is accepted in addition to FPGA_MAC; all other checks are unchanged.
- Undefined: only FPGA_MAC is accepted.

Test Plan:
- Common stimulus for every case: byte_valid pulsed every 2nd clock; 7×0x55 then 0xD5 preamble.
  - IP header: 8E 8E 00 20 8E 8E 8E 8E 8E 8E, checksum, src 8E×4, dst IP.
  - UDP header: src 8E 8E, dst port, length 00 0C, 8E 8E.
  - Then payload DEADBEEF and FCS 8E×4.
- Valid frame (MAC 00:1A:2B:3C:4D:5E, EtherType 0800, checksum E5F5, IP C0000292, port 5005) → exactly 4 payload_valid strobes DE, AD, BE, EF; payload_last only on EF.
- Destination MAC 10:1A:2B:3C:4D:5E or EtherType 86DD → no payload_valid during the frame.
- Checksum E5F6 with all else valid → no payload_valid.
- Destination IP C0AA0292 or port 8001 → no payload_valid.
- Two valid frames with data_valid low for ~1 clock between them → 8 strobes DEADBEEF DEADBEEF, payload_last twice.
- resetn asserted mid-payload → outputs 0 immediately. With ETH_PARSER_BROADCAST_EN defined, destination MAC FF:FF:FF:FF:FF:FF → DEADBEEF is delivered.
